// File: rtl/alu_arbiter_pkg.sv
// Shared widths, ALU command codes, slot encoding and bus payloads for the
// two-port ALU arbiter.
package alu_arbiter_pkg;

  localparam int unsigned WORD_LEN    = 32;
  localparam int unsigned EXE_CMD_LEN = 3;
  localparam int unsigned CTRL_W      = EXE_CMD_LEN + 1;
  localparam int unsigned SHAMT_W     = $clog2(WORD_LEN);

  typedef logic [WORD_LEN-1:0] word_t;
  typedef logic [CTRL_W-1:0]   ctrl_t;

  localparam ctrl_t ALU_AND     = 4'b0000;
  localparam ctrl_t ALU_OR      = 4'b0001;
  localparam ctrl_t ALU_ADD     = 4'b0010;
  localparam ctrl_t ALU_SUB     = 4'b0110;
  localparam ctrl_t ALU_SLT     = 4'b0111;
  localparam ctrl_t ALU_SHL     = 4'b1000;
  localparam ctrl_t ALU_SHL_ALT = 4'b1001;
  localparam ctrl_t ALU_SRL     = 4'b1010;
  localparam ctrl_t ALU_SRA     = 4'b1011;
  localparam ctrl_t ALU_XOR     = 4'b1100;
  localparam ctrl_t ALU_NOR     = 4'b1101;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  typedef struct packed {
    word_t a;
    word_t b;
    ctrl_t ctrl;
  } alu_req_t;

  typedef struct packed {
    word_t result;
    logic  zero;
  } alu_rsp_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// One requester port of the ALU arbiter: request and response valid/ready
// channels carrying packed payloads.
interface alu_arbiter_if;
  import alu_arbiter_pkg::*;

  logic     req_valid;
  logic     req_ready;
  alu_req_t req;
  logic     rsp_valid;
  logic     rsp_ready;
  alu_rsp_t rsp;

  modport master (
    output req_valid, req, rsp_ready,
    input  req_ready, rsp_valid, rsp
  );

  modport slave (
    input  req_valid, req, rsp_ready,
    output req_ready, rsp_valid, rsp
  );

endinterface

// File: rtl/alu_arbiter_alu.sv
// Combinational execute-stage ALU: result and zero flag for one command.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
(
  input  word_t a_i,
  input  word_t b_i,
  input  ctrl_t ctrl_i,
  output word_t res_c_o,
  output logic  zero_c_o
);

  logic               big_shamt_c;
  logic [SHAMT_W-1:0] shamt_c;
  word_t              res_c;

  // Shift amount is the whole b operand; anything >= WORD_LEN shifts out fully.
  assign big_shamt_c = (b_i >= word_t'(WORD_LEN));
  assign shamt_c     = b_i[SHAMT_W-1:0];

  always_comb begin
    res_c = '0;
    case (ctrl_i)
      ALU_ADD:     res_c = a_i + b_i;
      ALU_SUB:     res_c = a_i - b_i;
      ALU_AND:     res_c = a_i & b_i;
      ALU_OR:      res_c = a_i | b_i;
      ALU_SLT:     res_c = word_t'(a_i < b_i);
      ALU_XOR:     res_c = a_i ^ b_i;
      ALU_NOR:     res_c = ~(a_i | b_i);
      ALU_SHL,
      ALU_SHL_ALT: res_c = big_shamt_c ? '0 : (a_i << shamt_c);
      ALU_SRL:     res_c = big_shamt_c ? '0 : (a_i >> shamt_c);
      ALU_SRA:     res_c = big_shamt_c ? {WORD_LEN{a_i[WORD_LEN-1]}}
                                       : word_t'($signed(a_i) >>> shamt_c);
      default:     res_c = '0;
    endcase
  end

  assign res_c_o  = res_c;
  assign zero_c_o = (res_c == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between two requesters, with a one-entry
// result slot that can drain and refill in the same cycle.
module alu_arbiter
  import alu_arbiter_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  alu_arbiter_if.slave  p0_if,
  alu_arbiter_if.slave  p1_if
);

  slot_state_e state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic [1:0]  rsp_valid_q, rsp_valid_d;
  alu_rsp_t    rsp0_q, rsp0_d;
  alu_rsp_t    rsp1_q, rsp1_d;

  logic     owner_ready_c;
  logic     slot_free_c;
  logic     any_valid_c;
  logic     grant_c;
  logic     accept_c;
  alu_req_t alu_req_c;
  word_t    alu_res_c;
  logic     alu_zero_c;

  assign owner_ready_c = owner_q ? p1_if.rsp_ready : p0_if.rsp_ready;
  assign slot_free_c   = (state_q == SLOT_EMPTY) || owner_ready_c;
  assign any_valid_c   = p0_if.req_valid | p1_if.req_valid;

  // Under contention the port that did not win last time is granted.
  assign grant_c  = p0_if.req_valid ? (p1_if.req_valid & ~last_q) : 1'b1;
  assign accept_c = rst_n & slot_free_c & any_valid_c;

  assign p0_if.req_ready = accept_c & ~grant_c;
  assign p1_if.req_ready = accept_c &  grant_c;

  assign alu_req_c = grant_c ? p1_if.req : p0_if.req;

  alu_arbiter_alu u_alu (
    .a_i      (alu_req_c.a),
    .b_i      (alu_req_c.b),
    .ctrl_i   (alu_req_c.ctrl),
    .res_c_o  (alu_res_c),
    .zero_c_o (alu_zero_c)
  );

  // Slot next state: accept wins over drain, so drain+refill stays FULL.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    rsp0_d  = rsp0_q;
    rsp1_d  = rsp1_q;
    if (accept_c) begin
      state_d = SLOT_FULL;
      owner_d = grant_c;
      last_d  = grant_c;
      if (grant_c) begin
        rsp1_d = '{result: alu_res_c, zero: alu_zero_c};
      end else begin
        rsp0_d = '{result: alu_res_c, zero: alu_zero_c};
      end
    end else if ((state_q == SLOT_FULL) && owner_ready_c) begin
      state_d = SLOT_EMPTY;
    end
    rsp_valid_d[0] = (state_d == SLOT_FULL) && !owner_d;
    rsp_valid_d[1] = (state_d == SLOT_FULL) &&  owner_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SLOT_EMPTY;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      rsp_valid_q <= 2'b00;
      rsp0_q      <= '0;
      rsp1_q      <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      rsp_valid_q <= rsp_valid_d;
      rsp0_q      <= rsp0_d;
      rsp1_q      <= rsp1_d;
    end
  end

  assign p0_if.rsp_valid = rsp_valid_q[0];
  assign p1_if.rsp_valid = rsp_valid_q[1];
  assign p0_if.rsp       = rsp0_q;
  assign p1_if.rsp       = rsp1_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: reset, contention, back-pressure,
// streaming, edge-case ALU commands and reset during a pending result.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  alu_arbiter_if p0 ();
  alu_arbiter_if p1 ();

  alu_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .p0_if (p0.slave),
    .p1_if (p1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  word_t      e_a    [9];
  word_t      e_b    [9];
  ctrl_t      e_ctrl [9];
  word_t      e_res  [9];
  logic       e_zero [9];

  initial begin
    e_a[0] = 32'h8000_0000; e_b[0] = 32'd4;  e_ctrl[0] = ALU_SRA;     e_res[0] = 32'hF800_0000; e_zero[0] = 1'b0;
    e_a[1] = 32'd1;         e_b[1] = 32'd32; e_ctrl[1] = ALU_SHL;     e_res[1] = 32'h0;         e_zero[1] = 1'b1;
    e_a[2] = 32'd5;         e_b[2] = 32'd3;  e_ctrl[2] = 4'b1111;     e_res[2] = 32'h0;         e_zero[2] = 1'b1;
    e_a[3] = 32'h8000_0000; e_b[3] = 32'd31; e_ctrl[3] = ALU_SRL;     e_res[3] = 32'h1;         e_zero[3] = 1'b0;
    e_a[4] = 32'd1;         e_b[4] = 32'hFFFF_FFFF; e_ctrl[4] = ALU_SLT; e_res[4] = 32'h1;      e_zero[4] = 1'b0;
    e_a[5] = 32'h0;         e_b[5] = 32'h0;  e_ctrl[5] = ALU_NOR;     e_res[5] = 32'hFFFF_FFFF; e_zero[5] = 1'b0;
    e_a[6] = 32'h8000_0000; e_b[6] = 32'd40; e_ctrl[6] = ALU_SRA;     e_res[6] = 32'hFFFF_FFFF; e_zero[6] = 1'b0;
    e_a[7] = 32'hA5A5_A5A5; e_b[7] = 32'hA5A5_A5A5; e_ctrl[7] = ALU_XOR; e_res[7] = 32'h0;      e_zero[7] = 1'b1;
    e_a[8] = 32'd3;         e_b[8] = 32'd4;  e_ctrl[8] = ALU_SHL_ALT; e_res[8] = 32'h30;        e_zero[8] = 1'b0;

    rst_n = 1'b0;
    p0.req_valid = 1'b0; p0.rsp_ready = 1'b1; p0.req = '0;
    p1.req_valid = 1'b0; p1.rsp_ready = 1'b1; p1.req = '0;

    // Reset state, with requests presented while reset is held.
    #2;
    p0.req_valid = 1'b1;
    p1.req_valid = 1'b1;
    #1;
    chk("rst_ready", {30'd0, p1.req_ready, p0.req_ready}, 32'd0);
    chk("rst_rsp_valid", {30'd0, p1.rsp_valid, p0.rsp_valid}, 32'd0);
    chk("rst_rsp0_result", p0.rsp.result, 32'd0);
    chk("rst_rsp1_result", p1.rsp.result, 32'd0);
    chk("rst_rsp0_zero", p0.rsp.zero, 32'd0);

    // Contention from reset: port 0 first, then strict alternation.
    @(negedge clk);
    rst_n = 1'b1;
    p0.req = '{a: 32'd7, b: 32'd7, ctrl: ALU_SUB};
    p1.req = '{a: 32'hF0, b: 32'h0F, ctrl: ALU_OR};
    #1;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) begin
        chk($sformatf("cont_ready_%0d", i), {30'd0, p1.req_ready, p0.req_ready}, 32'd1);
        tick();
        chk($sformatf("cont_valid_%0d", i), {30'd0, p1.rsp_valid, p0.rsp_valid}, 32'd1);
        chk($sformatf("cont_res_%0d", i), p0.rsp.result, 32'd0);
        chk($sformatf("cont_zero_%0d", i), p0.rsp.zero, 32'd1);
      end else begin
        chk($sformatf("cont_ready_%0d", i), {30'd0, p1.req_ready, p0.req_ready}, 32'd2);
        tick();
        chk($sformatf("cont_valid_%0d", i), {30'd0, p1.rsp_valid, p0.rsp_valid}, 32'd2);
        chk($sformatf("cont_res_%0d", i), p1.rsp.result, 32'hFF);
        chk($sformatf("cont_zero_%0d", i), p1.rsp.zero, 32'd0);
      end
    end
    p0.req_valid = 1'b0;
    p1.req_valid = 1'b0;
    tick();
    chk("cont_drain", {30'd0, p1.rsp_valid, p0.rsp_valid}, 32'd0);

    // Single request on port 0.
    p0.req = '{a: 32'd5, b: 32'd3, ctrl: ALU_ADD};
    p0.req_valid = 1'b1;
    #1;
    chk("single_ready", {30'd0, p1.req_ready, p0.req_ready}, 32'd1);
    tick();
    p0.req_valid = 1'b0;
    chk("single_valid", {30'd0, p1.rsp_valid, p0.rsp_valid}, 32'd1);
    chk("single_res", p0.rsp.result, 32'd8);
    chk("single_zero", p0.rsp.zero, 32'd0);
    tick();
    chk("single_drain", {30'd0, p1.rsp_valid, p0.rsp_valid}, 32'd0);
    chk("single_hold", p0.rsp.result, 32'd8);

    // Back-pressure on port 0, then drain and refill from port 1.
    p0.rsp_ready = 1'b0;
    p0.req = '{a: 32'd10, b: 32'd4, ctrl: ALU_SUB};
    p0.req_valid = 1'b1;
    #1;
    chk("bp_ready0", {30'd0, p1.req_ready, p0.req_ready}, 32'd1);
    tick();
    p0.req_valid = 1'b0;
    p1.req = '{a: 32'd1, b: 32'd3, ctrl: ALU_AND};
    p1.req_valid = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("bp_stall_ready_%0d", k), {30'd0, p1.req_ready, p0.req_ready}, 32'd0);
      chk($sformatf("bp_stall_valid_%0d", k), {30'd0, p1.rsp_valid, p0.rsp_valid}, 32'd1);
      chk($sformatf("bp_stall_res_%0d", k), p0.rsp.result, 32'd6);
      tick();
    end
    p0.rsp_ready = 1'b1;
    #1;
    chk("bp_refill_ready", {30'd0, p1.req_ready, p0.req_ready}, 32'd2);
    tick();
    chk("bp_refill_valid", {30'd0, p1.rsp_valid, p0.rsp_valid}, 32'd2);
    chk("bp_refill_res", p1.rsp.result, 32'd1);
    chk("bp_p0_hold", p0.rsp.result, 32'd6);
    p1.req_valid = 1'b0;
    tick();
    chk("bp_drain", {30'd0, p1.rsp_valid, p0.rsp_valid}, 32'd0);

    // Streaming: 16 back-to-back adds on port 1.
    p1.req_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      p1.req = '{a: word_t'(i), b: 32'd100, ctrl: ALU_ADD};
      #1;
      chk($sformatf("stream_ready_%0d", i), {31'd0, p1.req_ready}, 32'd1);
      tick();
      chk($sformatf("stream_valid_%0d", i), {31'd0, p1.rsp_valid}, 32'd1);
      chk($sformatf("stream_res_%0d", i), p1.rsp.result, 32'(i + 100));
    end
    p1.req_valid = 1'b0;
    tick();
    chk("stream_drain", {31'd0, p1.rsp_valid}, 32'd0);

    // Edge-case commands on port 0.
    p0.req_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      p0.req = '{a: e_a[i], b: e_b[i], ctrl: e_ctrl[i]};
      #1;
      chk($sformatf("edge_ready_%0d", i), {31'd0, p0.req_ready}, 32'd1);
      tick();
      chk($sformatf("edge_valid_%0d", i), {31'd0, p0.rsp_valid}, 32'd1);
      chk($sformatf("edge_res_%0d", i), p0.rsp.result, e_res[i]);
      chk($sformatf("edge_zero_%0d", i), {31'd0, p0.rsp.zero}, {31'd0, e_zero[i]});
    end
    p0.req_valid = 1'b0;
    tick();

    // Reset while a result is held, then port 0 must win first contention.
    p0.rsp_ready = 1'b0;
    p0.req = '{a: 32'd1, b: 32'd1, ctrl: ALU_ADD};
    p0.req_valid = 1'b1;
    tick();
    p0.req_valid = 1'b0;
    chk("mid_full_valid", {31'd0, p0.rsp_valid}, 32'd1);
    chk("mid_full_res", p0.rsp.result, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {30'd0, p1.rsp_valid, p0.rsp_valid}, 32'd0);
    chk("mid_rst_res", p0.rsp.result, 32'd0);
    p0.req_valid = 1'b1;
    p1.req_valid = 1'b1;
    p0.rsp_ready = 1'b1;
    p0.req = '{a: 32'd2, b: 32'd2, ctrl: ALU_ADD};
    p1.req = '{a: 32'd9, b: 32'd9, ctrl: ALU_ADD};
    #1;
    chk("mid_rst_ready", {30'd0, p1.req_ready, p0.req_ready}, 32'd0);
    #1;
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", {30'd0, p1.req_ready, p0.req_ready}, 32'd1);
    tick();
    chk("post_rst_valid0", {30'd0, p1.rsp_valid, p0.rsp_valid}, 32'd1);
    chk("post_rst_res0", p0.rsp.result, 32'd4);
    chk("post_rst_ready1", {30'd0, p1.req_ready, p0.req_ready}, 32'd2);
    tick();
    chk("post_rst_valid1", {30'd0, p1.rsp_valid, p0.rsp_valid}, 32'd2);
    chk("post_rst_res1", p1.rsp.result, 32'd18);
    p0.req_valid = 1'b0;
    p1.req_valid = 1'b0;
    tick();
    chk("final_idle", {30'd0, p1.rsp_valid, p0.rsp_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
